// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Producer side of the stage-compare protocol.  For one detection window it
// walks the cascade stage by stage: fetches each stage descriptor from the
// stage table ROM, publishes the stage threshold and last-stage flag, streams
// the stage's weak-classifier indices to the feature pipeline, then waits for
// the compare controller to answer next_stage / done / break.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i, num_stages_i   start a cascade of num_stages_i stages (0 ignored)
//   busy_o                  sequencer not idle
//   stage_rd_o/addr_o       stage ROM read strobe / address
//   stage_rdata_i           descriptor {thr[31:0], first_clf, clf_num}, valid
//                           one cycle after stage_rd_o
//   stage_threshold_o       stage threshold, held for the whole stage
//   stage_threshold_val_o   1-cycle pulse when the threshold updates
//   stage_last_o            current stage is the final one (level)
//   stage_clear_o           1-cycle accumulator clear, with threshold_val
//   stage_idx_o             current stage index
//   clf_idx_o/val_o/last_o  weak-classifier index stream, clf_ready_i accepts
//   next_stage_i, done_i    compare controller answers (pulses)
//   break_i                 abort level from the compare controller
//   err_o                   sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int STAGE_W = 5,
    parameter int CLF_W   = 12,
    parameter int DESC_W  = 32 + 2 * CLF_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [STAGE_W-1:0] num_stages_i,
    output logic               busy_o,
    output logic               stage_rd_o,
    output logic [STAGE_W-1:0] stage_addr_o,
    input  logic [DESC_W-1:0]  stage_rdata_i,
    output logic [31:0]        stage_threshold_o,
    output logic               stage_threshold_val_o,
    output logic               stage_last_o,
    output logic               stage_clear_o,
    output logic [STAGE_W-1:0] stage_idx_o,
    output logic [CLF_W-1:0]   clf_idx_o,
    output logic               clf_val_o,
    output logic               clf_last_o,
    input  logic               clf_ready_i,
    input  logic               next_stage_i,
    input  logic               done_i,
    input  logic               break_i,
    output logic               err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [STAGE_W-1:0] ONE_STG = STAGE_W'(1);
    localparam logic [CLF_W-1:0]   ONE_CLF = CLF_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [STAGE_W-1:0] r_num_stages;
    logic [STAGE_W-1:0] r_stage_idx;
    logic [31:0]        r_thr;
    logic [CLF_W-1:0]   r_clf_base;
    logic [CLF_W-1:0]   r_clf_num;
    logic [CLF_W-1:0]   r_k;
    logic               r_thr_val;
    logic               r_last;
    logic               r_err;

    logic               w_start;
    logic               w_load;
    logic               w_adv;
    logic               w_next_stage;
    logic               w_err_set;
    logic               w_k_last;

    logic [31:0]        w_rd_thr;
    logic [CLF_W-1:0]   w_rd_first;
    logic [CLF_W-1:0]   w_rd_num;

    assign w_rd_thr   = stage_rdata_i[DESC_W-1 -: 32];
    assign w_rd_first = stage_rdata_i[2*CLF_W-1 -: CLF_W];
    assign w_rd_num   = stage_rdata_i[CLF_W-1:0];

    assign w_k_last   = (r_k == (r_clf_num - ONE_CLF));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes; break_i > done_i > next_stage_i
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        w_next_stage = 1'b0;
        w_err_set    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start_i && (num_stages_i != '0)) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH, S_LOAD, S_ISSUE: begin
                if (break_i) begin
                    w_state_nxt = S_IDLE;
                end else if (done_i || next_stage_i) begin
                    // Controller answered before the stage was fully issued
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_state == S_FETCH) begin
                    w_state_nxt = S_LOAD;
                end else if (r_state == S_LOAD) begin
                    w_load      = 1'b1;
                    w_state_nxt = (w_rd_num == '0) ? S_WAIT : S_ISSUE;
                end else if (clf_ready_i) begin
                    w_adv = 1'b1;
                    if (w_k_last) begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (break_i || done_i) begin
                    w_state_nxt = S_IDLE;
                end else if (next_stage_i) begin
                    if (r_last) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_next_stage = 1'b1;
                        w_state_nxt  = S_FETCH;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stage/classifier datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_num_stages <= '0;
            r_stage_idx  <= '0;
            r_thr        <= '0;
            r_clf_base   <= '0;
            r_clf_num    <= '0;
            r_k          <= '0;
            r_thr_val    <= 1'b0;
            r_last       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_start) begin
                r_num_stages <= num_stages_i;
                r_stage_idx  <= '0;
            end else if (w_next_stage) begin
                r_stage_idx <= r_stage_idx + ONE_STG;
            end

            // The pulse lands one cycle after LOAD, together with the new threshold
            r_thr_val <= w_load;

            if (w_load) begin
                r_thr      <= w_rd_thr;
                r_clf_base <= w_rd_first;
                r_clf_num  <= w_rd_num;
                r_k        <= '0;
                r_last     <= (r_stage_idx == (r_num_stages - ONE_STG));
            end else if (w_adv) begin
                r_k <= r_k + ONE_CLF;
            end

            // Leaving the cascade for any reason drops the last-stage level
            if ((w_state_nxt == S_IDLE) && (r_state != S_IDLE)) begin
                r_last <= 1'b0;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_o                = (r_state != S_IDLE);
    assign stage_rd_o            = (r_state == S_FETCH);
    assign stage_addr_o          = r_stage_idx;
    assign stage_idx_o           = r_stage_idx;
    assign stage_threshold_o     = r_thr;
    assign stage_threshold_val_o = r_thr_val;
    assign stage_clear_o         = r_thr_val;
    assign stage_last_o          = r_last;
    assign clf_val_o             = (r_state == S_ISSUE);
    assign clf_idx_o             = r_clf_base + r_k;   // wraps modulo 2^CLF_W
    assign clf_last_o            = (r_state == S_ISSUE) && w_k_last;
    assign err_o                 = r_err;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Directed bench for stage_sequencer: a per-cycle vector table for a complete
// three-stage cascade, plus hand-written sequences for backpressure, reject,
// break, empty stage, protocol errors and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    localparam int STAGE_W = 5;
    localparam int CLF_W   = 12;
    localparam int DESC_W  = 32 + 2 * CLF_W;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               start_i = 1'b0;
    logic [STAGE_W-1:0] num_stages_i = '0;
    logic               busy_o;
    logic               stage_rd_o;
    logic [STAGE_W-1:0] stage_addr_o;
    logic [DESC_W-1:0]  stage_rdata_i = '0;
    logic [31:0]        stage_threshold_o;
    logic               stage_threshold_val_o;
    logic               stage_last_o;
    logic               stage_clear_o;
    logic [STAGE_W-1:0] stage_idx_o;
    logic [CLF_W-1:0]   clf_idx_o;
    logic               clf_val_o;
    logic               clf_last_o;
    logic               clf_ready_i = 1'b0;
    logic               next_stage_i = 1'b0;
    logic               done_i = 1'b0;
    logic               break_i = 1'b0;
    logic               err_o;

    stage_sequencer #(
        .STAGE_W (STAGE_W),
        .CLF_W   (CLF_W),
        .DESC_W  (DESC_W)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .start_i               (start_i),
        .num_stages_i          (num_stages_i),
        .busy_o                (busy_o),
        .stage_rd_o            (stage_rd_o),
        .stage_addr_o          (stage_addr_o),
        .stage_rdata_i         (stage_rdata_i),
        .stage_threshold_o     (stage_threshold_o),
        .stage_threshold_val_o (stage_threshold_val_o),
        .stage_last_o          (stage_last_o),
        .stage_clear_o         (stage_clear_o),
        .stage_idx_o           (stage_idx_o),
        .clf_idx_o             (clf_idx_o),
        .clf_val_o             (clf_val_o),
        .clf_last_o            (clf_last_o),
        .clf_ready_i           (clf_ready_i),
        .next_stage_i          (next_stage_i),
        .done_i                (done_i),
        .break_i               (break_i),
        .err_o                 (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Stage table ROM model: one-cycle read latency
    logic [DESC_W-1:0] rom [0:31];
    always @(posedge clk_i) begin
        if (stage_rd_o) stage_rdata_i <= rom[stage_addr_o];
    end

    function automatic logic [DESC_W-1:0] mk(input logic [31:0] thr,
                                             input logic [CLF_W-1:0] first,
                                             input logic [CLF_W-1:0] num);
        return {thr, first, num};
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic             start;
        logic [4:0]       num;
        logic             ready;
        logic             nxt;
        logic             done;
        logic             brk;
        logic             busy;
        logic             rd;
        logic [4:0]       addr;
        logic             tv;
        logic             last;
        logic             val;
        logic [11:0]      idx;
        logic             clast;
        logic [31:0]      thr;
    } vec_t;

    function automatic vec_t v(input logic start, input logic [4:0] num, input logic ready,
                               input logic nxt, input logic done, input logic brk,
                               input logic busy, input logic rd, input logic [4:0] addr,
                               input logic tv, input logic last, input logic val,
                               input logic [11:0] idx, input logic clast, input logic [31:0] thr);
        vec_t r;
        r.start = start; r.num = num; r.ready = ready; r.nxt = nxt; r.done = done;
        r.brk = brk; r.busy = busy; r.rd = rd; r.addr = addr; r.tv = tv; r.last = last;
        r.val = val; r.idx = idx; r.clast = clast; r.thr = thr;
        return r;
    endfunction

    vec_t vecs [17];
    logic [CLF_W-1:0] acc [8];
    int n_acc;
    int n_rd;
    logic held;
    logic [CLF_W-1:0] held_idx;
    logic fin;
    logic rdy;

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = '0;

        // Row: inputs applied for one cycle, expected outputs after that edge
        vecs[0]  = v(1, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[1]  = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[2]  = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 1, 0, 0, 32'h3F800000);
        vecs[3]  = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 1, 1, 32'h0);
        vecs[4]  = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[5]  = v(0, 0, 1, 1, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0, 32'h0);
        vecs[6]  = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[7]  = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 1, 2, 0, 32'h40000000);
        vecs[8]  = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 3, 0, 32'h0);
        vecs[9]  = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 4, 1, 32'h0);
        vecs[10] = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[11] = v(0, 0, 1, 1, 0, 0,  1, 1, 2, 0, 0, 0, 0, 0, 32'h0);
        vecs[12] = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[13] = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 1, 1, 5, 1, 32'h40400000);
        vecs[14] = v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        vecs[15] = v(0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[16] = v(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // ---- reset state ----
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_rd", stage_rd_o, 0);
        chk("rst_thr", stage_threshold_o, 0);
        chk("rst_tv", stage_threshold_val_o, 0);
        chk("rst_val", clf_val_o, 0);
        chk("rst_idx", stage_idx_o, 0);
        chk("rst_err", err_o, 0);

        // ---- start with zero stages is ignored ----
        start_i = 1'b1; num_stages_i = 5'd0;
        tick();
        start_i = 1'b0;
        chk("zero_busy", busy_o, 0);
        chk("zero_rd", stage_rd_o, 0);
        tick();
        chk("zero_busy2", busy_o, 0);

        // ---- three-stage cascade, table driven ----
        rom[0] = mk(32'h3F800000, 12'd0, 12'd2);
        rom[1] = mk(32'h40000000, 12'd2, 12'd3);
        rom[2] = mk(32'h40400000, 12'd5, 12'd1);
        for (int i = 0; i < 17; i++) begin
            start_i      = vecs[i].start;
            num_stages_i = vecs[i].num;
            clf_ready_i  = vecs[i].ready;
            next_stage_i = vecs[i].nxt;
            done_i       = vecs[i].done;
            break_i      = vecs[i].brk;
            tick();
            chk($sformatf("v%0d_busy", i), busy_o, vecs[i].busy);
            chk($sformatf("v%0d_rd", i), stage_rd_o, vecs[i].rd);
            if (vecs[i].rd) chk($sformatf("v%0d_addr", i), stage_addr_o, vecs[i].addr);
            chk($sformatf("v%0d_tv", i), stage_threshold_val_o, vecs[i].tv);
            chk($sformatf("v%0d_clr", i), stage_clear_o, vecs[i].tv);
            if (vecs[i].tv) chk($sformatf("v%0d_thr", i), stage_threshold_o, vecs[i].thr);
            chk($sformatf("v%0d_last", i), stage_last_o, vecs[i].last);
            chk($sformatf("v%0d_val", i), clf_val_o, vecs[i].val);
            if (vecs[i].val) chk($sformatf("v%0d_cidx", i), clf_idx_o, vecs[i].idx);
            chk($sformatf("v%0d_clast", i), clf_last_o, vecs[i].clast);
            chk($sformatf("v%0d_err", i), err_o, 0);
        end
        start_i = 1'b0; next_stage_i = 1'b0; done_i = 1'b0; break_i = 1'b0;

        // ---- backpressure: ready toggles 1010 on {first=10, num=4} ----
        rom[0] = mk(32'h41000000, 12'd10, 12'd4);
        start_i = 1'b1; num_stages_i = 5'd1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("bp_tv", stage_threshold_val_o, 1);
        chk("bp_thr", stage_threshold_o, 32'h41000000);
        chk("bp_last", stage_last_o, 1);
        n_acc = 0; held = 1'b0; held_idx = '0; fin = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            rdy = (c % 2 == 0);
            clf_ready_i = rdy;
            if (held && clf_val_o) chk("bp_hold", clf_idx_o, held_idx);
            if (clf_val_o && rdy) begin
                if (n_acc < 8) acc[n_acc] = clf_idx_o;
                n_acc++;
            end
            held = clf_val_o && !rdy;
            held_idx = clf_idx_o;
            tick();
            if (!clf_val_o) fin = 1'b1;
        end
        chk("bp_fin", fin, 1);
        chk("bp_count", n_acc, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp_acc%0d", i), acc[i], 10 + i);
        chk("bp_wait_busy", busy_o, 1);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("bp_done_busy", busy_o, 0);

        // ---- reject at stage 0, then restart ----
        rom[0] = mk(32'h3F800000, 12'd0, 12'd2);
        clf_ready_i = 1'b1;
        start_i = 1'b1; num_stages_i = 5'd3;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rej_wait_val", clf_val_o, 0);
        chk("rej_wait_busy", busy_o, 1);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("rej_busy", busy_o, 0);
        n_rd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (stage_rd_o) n_rd++;
        end
        chk("rej_no_rd", n_rd, 0);
        start_i = 1'b1; num_stages_i = 5'd3;
        tick();
        start_i = 1'b0;
        chk("rej_restart_rd", stage_rd_o, 1);
        chk("rej_restart_addr", stage_addr_o, 0);
        chk("rej_restart_idx", stage_idx_o, 0);

        // ---- break mid-ISSUE with pending handshake ----
        clf_ready_i = 1'b0;
        tick();
        tick();
        chk("brk_val_pre", clf_val_o, 1);
        break_i = 1'b1;
        tick();
        break_i = 1'b0;
        chk("brk_val", clf_val_o, 0);
        chk("brk_busy", busy_o, 0);
        chk("brk_err", err_o, 0);
        chk("brk_tv", stage_threshold_val_o, 0);

        // ---- empty stage goes straight to WAIT; break in LOAD emits no pulse ----
        rom[0] = mk(32'h42000000, 12'd0, 12'd0);
        rom[1] = mk(32'h42800000, 12'd7, 12'd1);
        clf_ready_i = 1'b1;
        start_i = 1'b1; num_stages_i = 5'd2;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("empty_tv", stage_threshold_val_o, 1);
        chk("empty_val", clf_val_o, 0);
        chk("empty_busy", busy_o, 1);
        tick();
        chk("empty_val2", clf_val_o, 0);
        next_stage_i = 1'b1;
        tick();
        next_stage_i = 1'b0;
        chk("empty_next_rd", stage_rd_o, 1);
        chk("empty_next_addr", stage_addr_o, 1);
        tick();
        break_i = 1'b1;
        tick();
        break_i = 1'b0;
        chk("load_brk_busy", busy_o, 0);
        chk("load_brk_tv", stage_threshold_val_o, 0);
        chk("load_brk_err", err_o, 0);

        // ---- next_stage during ISSUE is a protocol error, sticky ----
        rom[0] = mk(32'h3F800000, 12'd0, 12'd2);
        clf_ready_i = 1'b0;
        start_i = 1'b1; num_stages_i = 5'd3;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        next_stage_i = 1'b1;
        tick();
        next_stage_i = 1'b0;
        chk("perr_err", err_o, 1);
        chk("perr_busy", busy_o, 0);
        tick();
        tick();
        chk("perr_sticky", err_o, 1);

        // ---- asynchronous reset mid-operation clears everything ----
        start_i = 1'b1; num_stages_i = 5'd3;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("arst_val_pre", clf_val_o, 1);
        rst_i = 1'b1;
        #2;
        chk("arst_busy", busy_o, 0);
        chk("arst_val", clf_val_o, 0);
        chk("arst_err", err_o, 0);
        chk("arst_thr", stage_threshold_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // ---- next_stage in WAIT of the last stage ----
        clf_ready_i = 1'b1;
        start_i = 1'b1; num_stages_i = 5'd1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("lerr_wait_last", stage_last_o, 1);
        chk("lerr_wait_busy", busy_o, 1);
        chk("lerr_wait_val", clf_val_o, 0);
        next_stage_i = 1'b1;
        tick();
        next_stage_i = 1'b0;
        chk("lerr_err", err_o, 1);
        chk("lerr_busy", busy_o, 0);
        chk("lerr_rd", stage_rd_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
